// File: rtl/fixed_point_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_point_pkg
//  Description : Shared Q-format constants, FSM state type and magnitude /
//                saturation helpers for the fixed-point arithmetic blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package fixed_point_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_FRAC  = 8;

    localparam logic [DEFAULT_WIDTH-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DEFAULT_WIDTH-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] value;
        logic                     overflow;
    } sat_t;

    // One extra bit so that |most-negative| is representable without wrapping.
    function automatic logic [DEFAULT_WIDTH:0] abs_mag(input logic [DEFAULT_WIDTH-1:0] v);
        if (v[DEFAULT_WIDTH-1])
            return {1'b0, ~v} + {{DEFAULT_WIDTH{1'b0}}, 1'b1};
        else
            return {1'b0, v};
    endfunction

    function automatic sat_t saturate(
        input logic                                  neg,
        input logic [DEFAULT_WIDTH+DEFAULT_FRAC-1:0] q
    );
        sat_t s;
        s.value    = '0;
        s.overflow = 1'b0;
        if (q == '0) begin
            s.value = '0;
        end else if (!neg) begin
            if (q > {{DEFAULT_FRAC{1'b0}}, Q_MAX}) begin
                s.value    = Q_MAX;
                s.overflow = 1'b1;
            end else begin
                s.value = q[DEFAULT_WIDTH-1:0];
            end
        end else begin
            if (q > {{DEFAULT_FRAC{1'b0}}, Q_MIN}) begin
                s.value    = Q_MIN;
                s.overflow = 1'b1;
            end else begin
                s.value = {DEFAULT_WIDTH{1'b0}} - q[DEFAULT_WIDTH-1:0];
            end
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_divider_if
//  Description : Start/done request interface of the Q-format divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fixed_divider_if
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] o_result;
    logic             overflow_flag;
    logic             div_zero_flag;
    logic             busy;
    logic             done;

    modport master (
        output start, dividend, divisor,
        input  o_result, overflow_flag, div_zero_flag, busy, done
    );

    modport slave (
        input  start, dividend, divisor,
        output o_result, overflow_flag, div_zero_flag, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/udiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : udiv_step
//  Description : One combinational restoring-division step on magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
module udiv_step
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic [WIDTH:0]   i_rem,
    input  wire logic             i_num_bit,
    input  wire logic [WIDTH-1:0] i_den,
    output logic      [WIDTH:0]   o_rem,
    output logic                  o_q_bit
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_den_ext;

    assign w_shift   = {i_rem[WIDTH-1:0], i_num_bit};
    assign w_den_ext = {1'b0, i_den};

    // A bit shifted out of the top means the true remainder already exceeds D.
    assign o_q_bit = i_rem[WIDTH] | (w_shift >= w_den_ext);
    assign o_rem   = o_q_bit ? (w_shift - w_den_ext) : w_shift;
endmodule
`default_nettype wire

// File: rtl/fixed_divider.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_divider
//  Description : Sequential signed Q8.8 restoring divider, one quotient bit
//                per clock, with saturation and divide-by-zero flagging.
//  Revision    : 1.0 - initial release
// ============================================================================
module fixed_divider
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int FRAC  = DEFAULT_FRAC
) (
    input  wire logic      clk,
    input  wire logic      reset,
    fixed_divider_if.slave bus
);
    localparam int                 c_ITERS = WIDTH + FRAC;
    localparam int                 c_CNT_W = $clog2(c_ITERS + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_ITERS - 1);

    state_t               r_state;
    logic                 r_sign;
    logic                 r_div_neg;
    logic                 r_zero;
    logic [c_ITERS-1:0]   r_num;
    logic [WIDTH-1:0]     r_den;
    logic [WIDTH:0]       r_rem;
    logic [c_ITERS-1:0]   r_quo;
    logic [c_CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]     r_result;
    logic                 r_ovf;
    logic                 r_dz;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH:0]       w_div_mag;
    logic [WIDTH:0]       w_den_mag;
    logic [WIDTH:0]       w_step_rem;
    logic                 w_step_q;
    sat_t                 w_sat;

    assign w_div_mag = abs_mag(bus.dividend);
    assign w_den_mag = abs_mag(bus.divisor);
    assign w_sat     = saturate(r_sign, r_quo);

    udiv_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_num_bit (r_num[c_ITERS-1]),
        .i_den     (r_den),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sign    <= 1'b0;
            r_div_neg <= 1'b0;
            r_zero    <= 1'b0;
            r_num     <= '0;
            r_den     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_count   <= '0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_dz      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sign    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        r_div_neg <= bus.dividend[WIDTH-1];
                        r_zero    <= (bus.divisor == '0);
                        r_num     <= c_ITERS'({w_div_mag, {FRAC{1'b0}}});
                        r_den     <= WIDTH'(w_den_mag);
                        r_rem     <= '0;
                        r_quo     <= '0;
                        r_count   <= '0;
                        r_busy    <= 1'b1;
                        // A zero divisor has a known answer; skip the iterations.
                        r_state   <= (bus.divisor == '0) ? FIN : CALC;
                    end
                end
                CALC: begin
                    r_rem   <= w_step_rem;
                    r_quo   <= {r_quo[c_ITERS-2:0], w_step_q};
                    r_num   <= {r_num[c_ITERS-2:0], 1'b0};
                    r_count <= r_count + c_CNT_W'(1);
                    if (r_count == c_LAST)
                        r_state <= FIN;
                end
                FIN: begin
                    if (r_zero) begin
                        r_result <= r_div_neg ? Q_MIN : Q_MAX;
                        r_ovf    <= 1'b1;
                        r_dz     <= 1'b1;
                    end else begin
                        r_result <= w_sat.value;
                        r_ovf    <= w_sat.overflow;
                        r_dz     <= 1'b0;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_result      = r_result;
    assign bus.overflow_flag = r_ovf;
    assign bus.div_zero_flag = r_dz;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
endmodule
`default_nettype wire

// File: tb/tb_fixed_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fixed_divider
//  Description : Self-checking bench for fixed_divider: arithmetic reference
//                model compared every cycle plus directed literal vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_divider;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fixed_divider_if #(.WIDTH(16)) bus ();

    fixed_divider #(.WIDTH(16), .FRAC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
        logic        dz;
    } outc_t;

    // Reference: exact integer division of magnitudes, then sign and clamp.
    function automatic outc_t ref_div(input logic [15:0] a, input logic [15:0] b);
        outc_t  o;
        int     sa;
        int     sb;
        longint ma;
        longint mb;
        longint q;
        bit     neg;
        sa = $signed(a);
        sb = $signed(b);
        o  = '0;
        if (sb == 0) begin
            o.res = (sa >= 0) ? 16'h7FFF : 16'h8000;
            o.ovf = 1'b1;
            o.dz  = 1'b1;
        end else begin
            ma  = (sa < 0) ? -longint'(sa) : longint'(sa);
            mb  = (sb < 0) ? -longint'(sb) : longint'(sb);
            q   = (ma * 256) / mb;
            neg = (sa < 0) != (sb < 0);
            if (q == 0) begin
                o.res = 16'h0000;
            end else if (!neg) begin
                if (q > 32767) begin o.res = 16'h7FFF; o.ovf = 1'b1; end
                else o.res = 16'(q);
            end else begin
                if (q > 32768) begin o.res = 16'h8000; o.ovf = 1'b1; end
                else o.res = 16'(-q);
            end
        end
        return o;
    endfunction

    // Timing model: a request accepted when idle completes 25 edges later
    // (1 edge for a zero divisor); outputs hold between completions.
    logic  m_valid = 1'b0;
    logic  m_busy  = 1'b0;
    logic  m_done  = 1'b0;
    int    m_left  = 0;
    outc_t m_out   = '0;
    outc_t m_pend  = '0;

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_left  <= 0;
            m_out   <= '0;
        end else if (m_valid) begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (bus.start === 1'b1) begin
                    m_pend <= ref_div(bus.dividend, bus.divisor);
                    m_busy <= 1'b1;
                    m_left <= (bus.divisor == 16'h0000) ? 1 : 25;
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_out  <= m_pend;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy",          bus.busy,          m_busy);
            check("done",          bus.done,          m_done);
            check("o_result",      bus.o_result,      m_out.res);
            check("overflow_flag", bus.overflow_flag, m_out.ovf);
            check("div_zero_flag", bus.div_zero_flag, m_out.dz);
        end
    end

    // Called right after start was driven at a negedge; returns edges from
    // the accepting edge to the one that raised done, -1 on timeout.
    task automatic wait_done(input bit hold, output int lat, output int busy_cnt);
        int n;
        n        = 0;
        busy_cnt = 0;
        lat      = -1;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) begin
                lat = n - 1;
                break;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (hold) begin
                bus.dividend = 16'($urandom);
                bus.divisor  = 16'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_res, input logic exp_ovf,
                           input logic exp_dz, input int exp_lat);
        int lat;
        int bc;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        wait_done(1'b0, lat, bc);
        bus.start = 1'b0;
        check("latency",     lat,               exp_lat);
        check("busy_cycles", bc,                exp_lat);
        check("lit_result",  bus.o_result,      exp_res);
        check("lit_ovf",     bus.overflow_flag, exp_ovf);
        check("lit_dz",      bus.div_zero_flag, exp_dz);
    endtask

    initial begin
        int lat;
        int bc;
        int dones;

        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 16'h0400;
        bus.divisor  = 16'h0200;
        repeat (3) @(negedge clk);
        check("rst_busy",   bus.busy,     32'd0);
        check("rst_done",   bus.done,     32'd0);
        check("rst_result", bus.o_result, 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        run_div(16'h0400, 16'h0200, 16'h0200, 1'b0, 1'b0, 25);
        run_div(16'hFA80, 16'h0200, 16'hFD40, 1'b0, 1'b0, 25);
        run_div(16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25);
        run_div(16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0, 25);
        run_div(16'h6400, 16'h0040, 16'h7FFF, 1'b1, 1'b0, 25);
        run_div(16'h9C00, 16'h0040, 16'h8000, 1'b1, 1'b0, 25);
        run_div(16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, 25);
        run_div(16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, 25);
        run_div(16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0, 25);
        run_div(16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 25);
        run_div(16'h0300, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1);
        run_div(16'hFD00, 16'h0000, 16'h8000, 1'b1, 1'b1, 1);
        run_div(16'h0400, 16'h0200, 16'h0200, 1'b0, 1'b0, 25);

        // Abort a division with reset part way through.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'h0C00;
        bus.divisor  = 16'h0200;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",   bus.busy,     32'd0);
        check("abort_result", bus.o_result, 32'd0);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        run_div(16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 25);

        // Start held high with inputs churning, then a back-to-back request.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'h0400;
        bus.divisor  = 16'h0200;
        wait_done(1'b1, lat, bc);
        check("hold_latency", lat,          32'd25);
        check("hold_result",  bus.o_result, 32'h0200);
        bus.dividend = 16'h0100;
        bus.divisor  = 16'h0300;
        wait_done(1'b0, lat, bc);
        bus.start = 1'b0;
        check("b2b_latency", lat,          32'd25);
        check("b2b_result",  bus.o_result, 32'h0055);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
